uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer directly upstream of the UART transmitter. It accepts bytes from the
//  host logic via a single-cycle write strobe and stores them in a circular FIFO.
//  It drains the FIFO into the transmitter one byte at a time over the send/done handshake.
//  Host logic can burst bytes without tracking transmitter occupancy.
// PARAMETERS
//  ADDR_W   4    FIFO address width; depth DEPTH = 2**ADDR_W (default 16 entries)
// PORTS
//  clock      in   1         single clock; all logic on posedge
//  reset_n    in   1         synchronous, active-low reset
//  wr_en      in   1         push wr_data this cycle
//  wr_data    in   8         byte to enqueue
//  clear_ovf  in   1         clears sticky overflow flag
//  full       out  1         count == DEPTH
//  empty      out  1         count == 0
//  count      out  ADDR_W+1  bytes currently stored (0..DEPTH)
//  overflow   out  1         sticky: write attempted while full
//  send       out  1         request to transmitter
//  data       out  8         byte presented to transmitter; stable while send=1
//  done       in   1         transmitter idle (1) / busy (0)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0,
//   send=0, data=8'h00, FSM=IDLE. Stored bytes are discarded. Reset mid-transfer
//   drops send on the next edge. The in-flight byte is not replayed.
//  FIFO: pointers are ADDR_W bits and wrap DEPTH-1 -> 0. count is a registered
//   up/down counter. push = wr_en & !full. pop is generated by the FSM only.
//   push and pop in the same cycle: count unchanged, both pointers advance.
//   wr_en while full: byte dropped, overflow<=1. This holds even if a pop occurs in the
//   same cycle, because full is sampled pre-edge.
//   clear_ovf and an overflowing write in the same cycle: overflow stays 1 (set wins).
//   full/empty/count are registered, valid the cycle after the edge that changes them.
//  Drain FSM (send/data registered):
//   IDLE: if !empty && done: data<=mem[rd_ptr], pop, send<=1 -> REQ. Otherwise stay, send=0.
//   REQ:  hold send=1, data stable. When done==0 sampled: send<=0 -> BUSY.
//         No timeout; waits indefinitely for done to fall.
//   BUSY: send=0. When done==1 sampled -> IDLE.
//  send must be low before done returns high, or the transmitter resends the byte.
//  REQ->BUSY guarantees this.
//  Latency: write at edge E0 into an empty FIFO with FSM IDLE and done=1 -> count=1 after E0.
//   At E1: pop, send=1, data=byte, count back to 0.
//  Throughput: one byte per transmitter frame plus 2 handshake cycles (REQ exit, BUSY exit).
//  done low at reset release: FSM stays in IDLE (no send) until done==1.
//  data holds the last byte after send falls. It changes only on IDLE->REQ.
// TESTING
//  1. Reset: hold reset_n=0 with wr_en=1 -> count=0, empty=1, send=0, data=00, overflow=0.
//  2. Single byte: write 8'hA5 with done=1 -> send=1, data=A5 one edge after count=1.
//     Model done falling 2 cycles later -> send falls next edge. tx serial = 0,1,0,1,0,0,1,0,1,1.
//  3. Burst: write 16 bytes 00..0F back-to-back with done held 0 -> full=1, count=16.
//     17th write (FF) -> dropped, overflow=1. Release done -> bytes transmitted in order 00..0F.
//  4. Wrap: write 12, drain 12, write 12 -> pointers wrap at 15->0.
//     All 24 bytes received in order; count returns to 0, empty=1.
//  5. Simultaneous push/pop at count=1 -> count stays 1. Write while full with pop same cycle
//     -> write dropped, overflow=1. clear_ovf pulse -> overflow=0.
//  6. Reset mid-transfer: assert reset_n=0 while FSM in REQ with 5 bytes queued
//     -> next edge send=0, count=0. No further send until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Circular byte FIFO feeding a UART transmitter over send/done.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clear_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              send,
    output logic [7:0]        data,
    input  logic              done
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    assign push = wr_en & ~full;
    assign pop  = (state == IDLE) & ~empty & done;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Storage is not reset: stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
            // A write that hits a full FIFO overrides a same-cycle clear.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // REQ waits for done to fall before dropping send, so send is already low
    // by the time the transmitter reports idle again.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            send  <= 1'b0;
            data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        data  <= mem[rd_ptr];
                        send  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!done) begin
                        send  <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    send  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed and randomized checks of uart_tx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            clear_ovf = 1'b0;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            send;
    logic [7:0]      data;
    logic            done = 1'b1;

    uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clear_ovf (clear_ovf),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .send      (send),
        .data      (data),
        .done      (done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored bytes as a queue, plus the handshake progress
    logic [7:0] q[$];
    logic [7:0] rx[$];
    logic [7:0] exp_bytes[$];
    logic       m_ovf = 1'b0;
    logic       m_handed = 1'b0;
    logic       m_low = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       tx_auto = 1'b0;
    int         tx_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic full_pre;
        @(posedge clock);
        if (!reset_n) begin
            q.delete();
            m_ovf    = 1'b0;
            m_handed = 1'b0;
            m_low    = 1'b0;
            m_data   = 8'h00;
        end else begin
            full_pre = (q.size() == DEPTH);
            if (wr_en && full_pre) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (m_handed && !m_low) begin
                if (!done) m_low = 1'b1;
            end else if (m_handed && m_low) begin
                if (done) m_handed = 1'b0;
            end else if (q.size() > 0 && done) begin
                m_data   = q.pop_front();
                m_handed = 1'b1;
                m_low    = 1'b0;
            end
            if (wr_en && !full_pre) q.push_back(wr_data);
        end
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("send", 32'(send), 32'(m_handed && !m_low));
        check("data", 32'(data), 32'(m_data));
        // Transmitter model: accept a byte, go busy for a few cycles, return idle
        if (tx_auto) begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) done = 1'b1;
            end else if (done && send) begin
                rx.push_back(data);
                done   = 1'b0;
                tx_cnt = $urandom_range(2, 6);
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int n);
        int guard;
        guard   = 0;
        tx_auto = 1'b1;
        done    = 1'b1;
        tx_cnt  = 0;
        while ((rx.size() < n || tx_cnt != 0 || send) && guard < 2000) begin
            step();
            guard++;
        end
        step();
        step();
        tx_auto = 1'b0;
        check("drain_done", 32'(rx.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] b;

        // Reset with a write strobe active
        wr_en = 1'b1;
        wr_data = 8'h5A;
        repeat (3) step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_send", 32'(send), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        wr_en = 1'b0;
        reset_n = 1'b1;
        step();

        // Single byte handshake
        write_byte(8'hA5);
        check("single_cnt1", 32'(count), 32'd1);
        check("single_nosend", 32'(send), 32'd0);
        step();
        check("single_send", 32'(send), 32'd1);
        check("single_data", 32'(data), 32'hA5);
        check("single_cnt0", 32'(count), 32'd0);
        step();
        step();
        done = 1'b0;
        step();
        check("single_sendfall", 32'(send), 32'd0);
        step();
        done = 1'b1;
        step();
        check("single_hold", 32'(data), 32'hA5);
        step();

        // Burst to full with the transmitter busy, then one overflowing write
        done = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        check("burst_full", 32'(full), 32'd1);
        check("burst_cnt", 32'(count), 32'd16);
        write_byte(8'hFF);
        check("burst_ovf", 32'(overflow), 32'd1);
        check("burst_cnt17", 32'(count), 32'd16);
        rx.delete();
        drain(16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx.size()) check("burst_order", 32'(rx[i]), 32'(i));
        end

        // Pointer wrap: 12 in, 12 out, 12 in, 12 out
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        rx.delete();
        exp_bytes.delete();
        for (int r = 0; r < 2; r++) begin
            done = 1'b0;
            for (int i = 0; i < 12; i++) begin
                b = 8'($urandom);
                exp_bytes.push_back(b);
                write_byte(b);
            end
            drain(12 * (r + 1));
        end
        for (int i = 0; i < 24; i++) begin
            if (i < rx.size()) check("wrap_order", 32'(rx[i]), 32'(exp_bytes[i]));
        end
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_cnt", 32'(count), 32'd0);

        // Simultaneous push and pop, then write-while-full with pop
        done = 1'b0;
        write_byte(8'h11);
        wr_en = 1'b1;
        wr_data = 8'h22;
        done = 1'b1;
        step();
        wr_en = 1'b0;
        check("pp_cnt", 32'(count), 32'd1);
        check("pp_data", 32'(data), 32'h11);
        done = 1'b0;
        step();
        for (int i = 0; i < 15; i++) write_byte(8'(8'h40 + i));
        check("pp_full", 32'(full), 32'd1);
        done = 1'b1;
        step();
        wr_en = 1'b1;
        wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        check("pf_ovf", 32'(overflow), 32'd1);
        check("pf_cnt", 32'(count), 32'd15);
        check("pf_data", 32'(data), 32'h22);
        done = 1'b0;
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("pf_clear", 32'(overflow), 32'd0);
        rx.delete();
        drain(15);

        // Reset while a request is outstanding
        done = 1'b0;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h80 + i));
        done = 1'b1;
        step();
        check("mid_send", 32'(send), 32'd1);
        check("mid_cnt", 32'(count), 32'd4);
        reset_n = 1'b0;
        step();
        check("mid_rst_send", 32'(send), 32'd0);
        check("mid_rst_cnt", 32'(count), 32'd0);
        reset_n = 1'b1;
        repeat (5) step();
        check("mid_quiet", 32'(send), 32'd0);

        // Randomized traffic with a live transmitter model
        tx_auto = 1'b1;
        tx_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            wr_en     = ($urandom_range(0, 99) < 45);
            wr_data   = 8'($urandom);
            clear_ovf = ($urandom_range(0, 99) < 3);
            reset_n   = ($urandom_range(0, 999) != 0);
            step();
        end
        wr_en = 1'b0;
        clear_ovf = 1'b0;
        reset_n = 1'b1;
        tx_auto = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
